// File: rtl/reduce_xor_pipe.sv
// rtl/reduce_xor_pipe.sv - pipelined FAN_IN-ary XOR reduction tree on a valid/ready stream
// Define REDUCE_XOR_PIPE_CLEAR_EN to zero stage data whenever a stage loads an empty slot.
module reduce_xor_pipe #(
    parameter int NUM_ELEMENTS  = 5,
    parameter int ELEMENT_WIDTH = 4,
    parameter int FAN_IN        = 2
) (
    input  logic                                  in_clock,
    input  logic                                  in_reset,
    input  logic [NUM_ELEMENTS*ELEMENT_WIDTH-1:0] in_elements,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    output logic [ELEMENT_WIDTH-1:0]              out_xor,
    output logic                                  out_valid,
    input  logic                                  out_ready
);

    function automatic int calc_levels(input int n, input int f);
        int l;
        int m;
        l = 0;
        m = n;
        while (m > 1) begin
            m = (m + f - 1) / f;
            l++;
        end
        return (l == 0) ? 1 : l;
    endfunction

    localparam int W      = ELEMENT_WIDTH;
    localparam int LEVELS = calc_levels(NUM_ELEMENTS, FAN_IN);
    localparam int N0     = (NUM_ELEMENTS + FAN_IN - 1) / FAN_IN;
    localparam int PADN   = N0 * FAN_IN;

    // Every level is sized for the widest level; words past n_k stay zero, so a
    // plain XOR over the zero-padded upstream yields the partial last group too.
    logic [N0-1:0][W-1:0]   data_q [LEVELS];
    logic [N0-1:0][W-1:0]   data_d [LEVELS];
    logic [PADN-1:0][W-1:0] src    [LEVELS];
    logic [LEVELS-1:0]      valid_q;
    logic [LEVELS-1:0]      up_valid;
    logic [LEVELS-1:0]      rdy;

    // r_k = out_ready or any stage at or after k is empty
    always_comb begin
        logic acc;
        acc = out_ready;
        rdy = '0;
        for (int k = LEVELS - 1; k >= 0; k--) begin
            acc    = acc | ~valid_q[k];
            rdy[k] = acc;
        end
    end

    assign in_ready  = rdy[0];
    assign out_valid = valid_q[LEVELS-1];

    always_comb begin
        logic [W-1:0] acc;
        src[0]                    = '0;
        src[0][NUM_ELEMENTS-1:0]  = in_elements;
        up_valid                  = '0;
        up_valid[0]               = in_valid;
        for (int k = 1; k < LEVELS; k++) begin
            src[k]         = '0;
            src[k][N0-1:0] = data_q[k-1];
            up_valid[k]    = valid_q[k-1];
        end
        for (int k = 0; k < LEVELS; k++) begin
            for (int g = 0; g < N0; g++) begin
                acc = '0;
                for (int j = 0; j < FAN_IN; j++) begin
                    acc = acc ^ src[k][g*FAN_IN+j];
                end
                data_d[k][g] = acc;
            end
`ifdef REDUCE_XOR_PIPE_CLEAR_EN
            if (!up_valid[k]) begin
                data_d[k] = '0;
            end
`endif
        end
    end

    always_ff @(posedge in_clock or posedge in_reset) begin
        if (in_reset) begin
            valid_q <= '0;
            for (int k = 0; k < LEVELS; k++) begin
                data_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < LEVELS; k++) begin
                if (rdy[k]) begin
                    valid_q[k] <= up_valid[k];
                    data_q[k]  <= data_d[k];
                end
            end
        end
    end

    // Only word 0 of the last level is ever non-zero; folding all words keeps every bit live.
    always_comb begin
        out_xor = '0;
        for (int g = 0; g < N0; g++) begin
            out_xor = out_xor ^ data_q[LEVELS-1][g];
        end
    end

endmodule

// File: tb/tb_reduce_xor_pipe.sv
// tb/tb_reduce_xor_pipe.sv - randomized scoreboard bench for reduce_xor_pipe (REDUCE_XOR_PIPE_CLEAR_EN optional)
module tb_reduce_xor_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic [19:0] in_elements;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  out_xor;
    logic        out_valid;
    logic        out_ready;

    logic [3:0]  in1_elements;
    logic        in1_valid;
    logic        in1_ready;
    logic [3:0]  out1_xor;
    logic        out1_valid;
    logic [27:0] in7_elements;
    logic        in7_valid;
    logic        in7_ready;
    logic [3:0]  out7_xor;
    logic        out7_valid;

    int tests_run    = 0;
    int tests_failed = 0;
    int accepted     = 0;
    int outs         = 0;
    logic [3:0] exp_q[$];
    logic [3:0] last_out;
    logic [3:0] prev_xor;
    logic       prev_stall = 1'b0;
    logic       done;

    always #5 clk = ~clk;

    reduce_xor_pipe #(.NUM_ELEMENTS(5), .ELEMENT_WIDTH(4), .FAN_IN(2)) dut (
        .in_clock(clk), .in_reset(rst), .in_elements(in_elements), .in_valid(in_valid),
        .in_ready(in_ready), .out_xor(out_xor), .out_valid(out_valid), .out_ready(out_ready));

    reduce_xor_pipe #(.NUM_ELEMENTS(1), .ELEMENT_WIDTH(4), .FAN_IN(2)) dut1 (
        .in_clock(clk), .in_reset(rst), .in_elements(in1_elements), .in_valid(in1_valid),
        .in_ready(in1_ready), .out_xor(out1_xor), .out_valid(out1_valid), .out_ready(1'b1));

    reduce_xor_pipe #(.NUM_ELEMENTS(7), .ELEMENT_WIDTH(4), .FAN_IN(3)) dut7 (
        .in_clock(clk), .in_reset(rst), .in_elements(in7_elements), .in_valid(in7_valid),
        .in_ready(in7_ready), .out_xor(out7_xor), .out_valid(out7_valid), .out_ready(1'b1));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] model_xor(input logic [31:0] e, input int n);
        logic [3:0] r;
        r = 4'h0;
        for (int i = 0; i < n; i++) r = r ^ 4'((e >> (4 * i)) & 32'hF);
        return r;
    endfunction

    // Scoreboard: handshakes resolve at the next rising edge, so sample them mid-cycle.
    always @(negedge clk) begin
        if (!rst) begin
            if (prev_stall) begin
                check("hold_valid", 32'(out_valid), 32'd1);
                check("hold_data", 32'(out_xor), 32'(prev_xor));
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model_xor(32'(in_elements), 5));
                accepted++;
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) check("unexpected_out", 32'(out_xor), 32'hDEAD);
                else check("out_xor", 32'(out_xor), 32'(exp_q.pop_front()));
                last_out = out_xor;
                outs++;
            end
`ifdef REDUCE_XOR_PIPE_CLEAR_EN
            if (!out_valid) check("clear_out", 32'(out_xor), 32'd0);
`endif
            prev_stall = out_valid && !out_ready;
            prev_xor   = out_xor;
        end
    end

    task automatic send(input logic [19:0] e);
        int n;
        in_elements = e;
        in_valid    = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (n >= 50) check("send_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 40) begin
            @(posedge clk);
            n++;
        end
        #1;
        check(tag, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int a0;
        int o0;
        time t0;
        logic [19:0] r;
        logic [27:0] r7;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; in_elements = '0;
        in1_valid = 1'b0; in1_elements = '0; in7_valid = 1'b0; in7_elements = '0;
        #2;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_xor", 32'(out_xor), 32'd0);
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        @(posedge clk); #1;

        // single beat: e0..e4 = 1,2,4,8,3 -> C after exactly 3 cycles
        in_elements = 20'h38421; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            check($sformatf("latency_c%0d", c), 32'(out_valid), (c == 3) ? 32'd1 : 32'd0);
        end
        check("single_value", 32'(out_xor), 32'hC);
        drain("single_drain");

        // back-to-back stream at one beat per cycle
        o0 = outs;
        t0 = $time;
        for (int i = 0; i < 8; i++) begin
            r = 20'($urandom());
            send(r);
        end
        check("stream_rate", 32'(($time - t0) / 10), 32'd8);
        drain("stream_drain");
        check("stream_count", 32'(outs - o0), 32'd8);

        // stall: capacity is exactly LEVELS beats
        out_ready = 1'b0;
        a0 = accepted;
        o0 = outs;
        in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_elements = 20'($urandom());
            @(posedge clk); #1;
        end
        check("stall_accepted", 32'(accepted - a0), 32'd3);
        check("stall_in_ready", 32'(in_ready), 32'd0);
        in_valid = 1'b0;
        out_ready = 1'b1;
        drain("stall_drain");
        check("stall_count", 32'(outs - o0), 32'd3);

        // random traffic with random backpressure
        done = 1'b0;
        o0 = outs;
        fork
            begin
                for (int i = 0; i < 30; i++) begin
                    if ($urandom_range(3) == 0) begin
                        @(posedge clk); #1;
                    end
                    r = 20'($urandom());
                    send(r);
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk); #1;
                    out_ready = 1'($urandom_range(1));
                end
            end
        join
        out_ready = 1'b1;
        drain("random_drain");
        check("random_count", 32'(outs - o0), 32'd30);

        // reset with two beats in flight
        o0 = outs;
        in_elements = 20'h12345; in_valid = 1'b1;
        @(posedge clk); #1;
        in_elements = 20'h9ABCD;
        @(posedge clk); #1;
        in_valid = 1'b0;
        #1 rst = 1'b1;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_out_xor", 32'(out_xor), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        exp_q.delete();
        prev_stall = 1'b0;
        @(posedge clk); #2 rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("flushed_no_out", 32'(outs - o0), 32'd0);
        send(20'h0000F);
        drain("post_rst_drain");
        check("post_rst_value", 32'(last_out), 32'hF);

        // NUM_ELEMENTS=1 (latency 1) and NUM_ELEMENTS=7, FAN_IN=3 (latency 2)
        r7 = 28'($urandom());
        in1_elements = 4'hA; in1_valid = 1'b1;
        in7_elements = r7;   in7_valid = 1'b1;
        @(posedge clk); #1;
        in1_valid = 1'b0; in7_valid = 1'b0;
        @(negedge clk);
        check("n1_valid_c1", 32'(out1_valid), 32'd1);
        check("n1_value", 32'(out1_xor), 32'hA);
        check("n7_valid_c1", 32'(out7_valid), 32'd0);
        @(negedge clk);
        check("n1_valid_c2", 32'(out1_valid), 32'd0);
        check("n7_valid_c2", 32'(out7_valid), 32'd1);
        check("n7_value", 32'(out7_xor), 32'(model_xor(32'(r7), 7)));
        repeat (4) @(negedge clk);
        check("n1_in_ready", 32'(in1_ready), 32'd1);
        check("n7_in_ready", 32'(in7_ready), 32'd1);
`ifdef REDUCE_XOR_PIPE_CLEAR_EN
        check("idle_n1_xor", 32'(out1_xor), 32'd0);
        check("idle_n7_xor", 32'(out7_xor), 32'd0);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("idle_stage%0d", k), 32'(dut.data_q[k]), 32'd0);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
